// File: rtl/mips_multiciclo_controle.sv
// ---------------------------------------------------------------------------
// mips_multiciclo_controle
//
// Multicycle control FSM for the MIPS core. One shared memory and one shared
// ALU are sequenced across FETCH / DECODE / EXECUTE / MEM / WB states for
// add, sub, and, or, slt, lw, sw, beq, addi and j.
//
// Parameters
//   WAIT_MEM : 1 = memory states hold until mem_ready, 0 = memory always ready
//   CNT_W    : width of the retired-instruction counter
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   OP, Funct           : opcode / funct fields from the instruction register
//   mem_ready           : memory finished the current access this cycle
//   mem_req, IorD       : memory request, address select (0 = PC, 1 = ALUOut)
//   MemWrite, IRWrite   : memory write strobe, instruction register load
//   PCWrite, Branch     : unconditional PC load, PC load if ALU zero
//   PCSrc               : 00 ALU result, 01 ALUOut, 10 jump target
//   ALUSrcA, ALUSrcB    : ALU operand selects
//   ULA_Control         : ALU operation
//   RegDst, MemtoReg    : register file destination / write-data selects
//   RegWrite            : register file write enable
//   illegal_op          : one-cycle pulse on unsupported OP / Funct
//   instr_done          : one-cycle pulse in the retiring cycle
//   instr_count         : retired-instruction counter (wraps)
//   state_o             : current state encoding
// ---------------------------------------------------------------------------
module mips_multiciclo_controle #(
   parameter int WAIT_MEM = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       OP,
   input  logic [5:0]       Funct,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic [1:0]       PCSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ULA_Control,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             illegal_op,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEXEC = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mem_ok;
   logic [2:0]       funct_ula;
   logic             funct_ok;

   // With WAIT_MEM=0 the memory is treated as single-cycle and mem_ready is ignored.
   assign mem_ok = (WAIT_MEM == 0) ? 1'b1 : mem_ready;

   // R-type funct decode; unknown functs fall back to AND and are flagged.
   always_comb begin
      funct_ula = 3'b000;
      funct_ok  = 1'b1;
      case (Funct)
         6'b100000: funct_ula = 3'b010;
         6'b100010: funct_ula = 3'b110;
         6'b100100: funct_ula = 3'b000;
         6'b100101: funct_ula = 3'b001;
         6'b101010: funct_ula = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH:    if (mem_ok) state_d = S_DECODE;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;  // PC already advanced by 4
            endcase
         end
         S_MEMADR:   state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
         S_EXECUTE:  state_d = funct_ok ? S_ALUWB : S_FETCH;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_ADDIEXEC: state_d = S_ADDIWB;
         S_ADDIWB:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         default:    state_d = S_IDLE;   // unused encodings recover through IDLE
      endcase
   end

   // Control outputs are decoded from the registered state. IRWrite/PCWrite in
   // FETCH and the illegal-op flags depend on same-cycle inputs, so they cannot
   // be pre-registered without losing a cycle.
   always_comb begin
      mem_req     = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      Branch      = 1'b0;
      PCSrc       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ULA_Control = 3'b000;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req     = 1'b1;
            ALUSrcB     = 2'b01;
            ULA_Control = 3'b010;
            IRWrite     = mem_ok;
            PCWrite     = mem_ok;
         end
         S_DECODE: begin
            ALUSrcB     = 2'b11;   // precompute branch target into ALUOut
            ULA_Control = 3'b010;
            case (OP)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
               default:                                      illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ULA_Control = 3'b010;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ok;
         end
         S_EXECUTE: begin
            ALUSrcA     = 1'b1;
            ULA_Control = funct_ula;
            illegal_op  = ~funct_ok;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ULA_Control = 3'b110;
            Branch      = 1'b1;
            PCSrc       = 2'b01;
            instr_done  = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ULA_Control = 3'b010;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign count_d = instr_done ? count_q + CNT_W'(1) : count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_mips_multiciclo_controle.sv
// ---------------------------------------------------------------------------
// tb_mips_multiciclo_controle
//
// Table-driven check of the multicycle control FSM (WAIT_MEM=1, CNT_W=16),
// plus a hand-written sequence on a second instance (WAIT_MEM=0, CNT_W=3)
// covering counter wrap and memory states that ignore mem_ready.
// Control word packing:
//   {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc[1:0],
//    ALUSrcA, ALUSrcB[1:0], ULA_Control[2:0],
//    RegDst, MemtoReg, RegWrite, illegal_op, instr_done}
// ---------------------------------------------------------------------------
module tb_mips_multiciclo_controle;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_BAD   = 6'b000111;

   // Expected control words, written out from the state table.
   localparam logic [18:0] W_IDLE       = 19'd0;
   localparam logic [18:0] W_FETCH_RDY  = {6'b100110, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
   localparam logic [18:0] W_FETCH_WAIT = {6'b100000, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
   localparam logic [18:0] W_DECODE     = {6'b000000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00000};
   localparam logic [18:0] W_DECODE_ILL = {6'b000000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00010};
   localparam logic [18:0] W_MEMADR     = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
   localparam logic [18:0] W_MEMRD      = {6'b110000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
   localparam logic [18:0] W_MEMWB      = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b01101};
   localparam logic [18:0] W_MEMWR_WAIT = {6'b111000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
   localparam logic [18:0] W_MEMWR_RDY  = {6'b111000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00001};
   localparam logic [18:0] W_EXE_ADD    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b010, 5'b00000};
   localparam logic [18:0] W_EXE_SUB    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b110, 5'b00000};
   localparam logic [18:0] W_EXE_AND    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b000, 5'b00000};
   localparam logic [18:0] W_EXE_OR     = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b001, 5'b00000};
   localparam logic [18:0] W_EXE_SLT    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b111, 5'b00000};
   localparam logic [18:0] W_EXE_ILL    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b000, 5'b00010};
   localparam logic [18:0] W_ALUWB      = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10101};
   localparam logic [18:0] W_BRANCH     = {6'b000001, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00001};
   localparam logic [18:0] W_ADDIEX     = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
   localparam logic [18:0] W_ADDIWB     = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00101};
   localparam logic [18:0] W_JUMP       = {6'b000010, 2'b10, 1'b0, 2'b00, 3'b000, 5'b00001};

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        mem_ready;
      logic [3:0]  exp_state;
      logic [18:0] exp_ctl;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   int tests_run = 0;
   int tests_failed = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance 1: WAIT_MEM=1, CNT_W=16 ----------------
   logic        rst_n, mem_ready;
   logic [5:0]  op, funct;
   logic        mem_req, iord, memwrite, irwrite, pcwrite, branch;
   logic [1:0]  pcsrc, alusrcb;
   logic        alusrca, regdst, memtoreg, regwrite, illegal_op, instr_done;
   logic [2:0]  ula;
   logic [15:0] instr_count;
   logic [3:0]  state;
   logic [18:0] ctl;

   mips_multiciclo_controle #(.WAIT_MEM(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .OP(op), .Funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(iord), .MemWrite(memwrite), .IRWrite(irwrite),
      .PCWrite(pcwrite), .Branch(branch), .PCSrc(pcsrc), .ALUSrcA(alusrca),
      .ALUSrcB(alusrcb), .ULA_Control(ula), .RegDst(regdst), .MemtoReg(memtoreg),
      .RegWrite(regwrite), .illegal_op(illegal_op), .instr_done(instr_done),
      .instr_count(instr_count), .state_o(state)
   );

   assign ctl = {mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
                 alusrca, alusrcb, ula, regdst, memtoreg, regwrite, illegal_op, instr_done};

   // ---------------- instance 2: WAIT_MEM=0, CNT_W=3 ----------------
   logic        rst2_n, mem_ready2;
   logic [5:0]  op2, funct2;
   logic        mem_req2, iord2, memwrite2, irwrite2, pcwrite2, branch2;
   logic [1:0]  pcsrc2, alusrcb2;
   logic        alusrca2, regdst2, memtoreg2, regwrite2, illegal_op2, instr_done2;
   logic [2:0]  ula2;
   logic [2:0]  instr_count2;
   logic [3:0]  state2;
   logic [18:0] ctl2;

   mips_multiciclo_controle #(.WAIT_MEM(0), .CNT_W(3)) dut2 (
      .clk(clk), .rst_n(rst2_n), .OP(op2), .Funct(funct2), .mem_ready(mem_ready2),
      .mem_req(mem_req2), .IorD(iord2), .MemWrite(memwrite2), .IRWrite(irwrite2),
      .PCWrite(pcwrite2), .Branch(branch2), .PCSrc(pcsrc2), .ALUSrcA(alusrca2),
      .ALUSrcB(alusrcb2), .ULA_Control(ula2), .RegDst(regdst2), .MemtoReg(memtoreg2),
      .RegWrite(regwrite2), .illegal_op(illegal_op2), .instr_done(instr_done2),
      .instr_count(instr_count2), .state_o(state2)
   );

   assign ctl2 = {mem_req2, iord2, memwrite2, irwrite2, pcwrite2, branch2, pcsrc2,
                  alusrca2, alusrcb2, ula2, regdst2, memtoreg2, regwrite2, illegal_op2, instr_done2};

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic mr,
                      input logic [3:0] st, input logic [18:0] w, input logic [15:0] cnt);
      vec_t v;
      v.rst_n = r; v.op = o; v.funct = f; v.mem_ready = mr;
      v.exp_state = st; v.exp_ctl = w; v.exp_count = cnt;
      vecs.push_back(v);
   endtask

   // Zero-wait R-type: FETCH, DECODE, EXECUTE, ALUWB.
   task automatic add_rtype(input logic [5:0] f, input logic [18:0] w_exe, input logic [15:0] cnt);
      add(1, OP_R, f, 1, 4'd1, W_FETCH_RDY, cnt);
      add(1, OP_R, f, 1, 4'd2, W_DECODE,    cnt);
      add(1, OP_R, f, 1, 4'd7, w_exe,       cnt);
      add(1, OP_R, f, 1, 4'd8, W_ALUWB,     cnt);
   endtask

   task automatic step2_check(input string name, input logic [3:0] st, input logic [18:0] w,
                              input logic [2:0] cnt);
      @(negedge clk);
      #1;
      check({name, " state"}, 32'(state2), 32'(st));
      check({name, " ctl"},   32'(ctl2),   32'(w));
      check({name, " count"}, 32'(instr_count2), 32'(cnt));
      $display("[TB] dut2 %s state=%0d ctl=0x%05h count=%0d", name, state2, ctl2, instr_count2);
   endtask

   initial begin
      // ---- vector table ----
      add(1, OP_R, F_ADD, 1, 4'd0, W_IDLE, 16'd0);          // reset released
      add_rtype(F_ADD, W_EXE_ADD, 16'd0);
      // lw: 2 wait cycles in FETCH, 3 in MEMREAD
      add(1, OP_LW, F_ADD, 0, 4'd1, W_FETCH_WAIT, 16'd1);
      add(1, OP_LW, F_ADD, 0, 4'd1, W_FETCH_WAIT, 16'd1);
      add(1, OP_LW, F_ADD, 1, 4'd1, W_FETCH_RDY,  16'd1);
      add(1, OP_LW, F_ADD, 1, 4'd2, W_DECODE,     16'd1);
      add(1, OP_LW, F_ADD, 1, 4'd3, W_MEMADR,     16'd1);
      add(1, OP_LW, F_ADD, 0, 4'd4, W_MEMRD,      16'd1);
      add(1, OP_LW, F_ADD, 0, 4'd4, W_MEMRD,      16'd1);
      add(1, OP_LW, F_ADD, 0, 4'd4, W_MEMRD,      16'd1);
      add(1, OP_LW, F_ADD, 1, 4'd4, W_MEMRD,      16'd1);
      add(1, OP_LW, F_ADD, 1, 4'd5, W_MEMWB,      16'd1);
      // sw, beq, j zero-wait
      add(1, OP_SW, F_ADD, 1, 4'd1, W_FETCH_RDY,  16'd2);
      add(1, OP_SW, F_ADD, 1, 4'd2, W_DECODE,     16'd2);
      add(1, OP_SW, F_ADD, 1, 4'd3, W_MEMADR,     16'd2);
      add(1, OP_SW, F_ADD, 1, 4'd6, W_MEMWR_RDY,  16'd2);
      add(1, OP_BEQ, F_ADD, 1, 4'd1, W_FETCH_RDY, 16'd3);
      add(1, OP_BEQ, F_ADD, 1, 4'd2, W_DECODE,    16'd3);
      add(1, OP_BEQ, F_ADD, 1, 4'd9, W_BRANCH,    16'd3);
      add(1, OP_J, F_ADD, 1, 4'd1, W_FETCH_RDY,   16'd4);
      add(1, OP_J, F_ADD, 1, 4'd2, W_DECODE,      16'd4);
      add(1, OP_J, F_ADD, 1, 4'd12, W_JUMP,       16'd4);
      // illegal OP, then illegal Funct
      add(1, OP_BAD, F_ADD, 1, 4'd1, W_FETCH_RDY,  16'd5);
      add(1, OP_BAD, F_ADD, 1, 4'd2, W_DECODE_ILL, 16'd5);
      add(1, OP_R, F_BAD, 1, 4'd1, W_FETCH_RDY,    16'd5);
      add(1, OP_R, F_BAD, 1, 4'd2, W_DECODE,       16'd5);
      add(1, OP_R, F_BAD, 1, 4'd7, W_EXE_ILL,      16'd5);
      // remaining R-type functs and addi
      add_rtype(F_SUB, W_EXE_SUB, 16'd5);
      add(1, OP_ADDI, F_ADD, 1, 4'd1,  W_FETCH_RDY, 16'd6);
      add(1, OP_ADDI, F_ADD, 1, 4'd2,  W_DECODE,    16'd6);
      add(1, OP_ADDI, F_ADD, 1, 4'd10, W_ADDIEX,    16'd6);
      add(1, OP_ADDI, F_ADD, 1, 4'd11, W_ADDIWB,    16'd6);
      add_rtype(F_AND, W_EXE_AND, 16'd7);
      add_rtype(F_OR,  W_EXE_OR,  16'd8);
      add_rtype(F_SLT, W_EXE_SLT, 16'd9);
      // sw stalled in MEMWRITE, reset asserted there
      add(1, OP_SW, F_ADD, 1, 4'd1, W_FETCH_RDY,  16'd10);
      add(1, OP_SW, F_ADD, 1, 4'd2, W_DECODE,     16'd10);
      add(1, OP_SW, F_ADD, 1, 4'd3, W_MEMADR,     16'd10);
      add(1, OP_SW, F_ADD, 0, 4'd6, W_MEMWR_WAIT, 16'd10);
      add(0, OP_SW, F_ADD, 0, 4'd6, W_MEMWR_WAIT, 16'd10);
      add(1, OP_SW, F_ADD, 0, 4'd0, W_IDLE,       16'd0);
      add(1, OP_SW, F_ADD, 0, 4'd1, W_FETCH_WAIT, 16'd0);

      // ---- reset both instances ----
      rst_n = 1'b0; op = OP_R; funct = F_ADD; mem_ready = 1'b1;
      rst2_n = 1'b0; op2 = OP_J; funct2 = F_ADD; mem_ready2 = 1'b0;
      repeat (2) @(posedge clk);

      // ---- apply table ----
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; op = vecs[i].op; funct = vecs[i].funct;
         mem_ready = vecs[i].mem_ready;
         #1;
         check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d ctl", i),   32'(ctl),   32'(vecs[i].exp_ctl));
         check($sformatf("vec%0d count", i), 32'(instr_count), 32'(vecs[i].exp_count));
         $display("[TB] vec %0d rst_n=%0b op=%06b funct=%06b mr=%0b state=%0d ctl=0x%05h count=%0d",
                  i, rst_n, op, funct, mem_ready, state, ctl, instr_count);
      end

      // ---- dut2: WAIT_MEM=0, 3-bit counter wrap ----
      @(negedge clk);
      rst2_n = 1'b1;
      #1;
      check("dut2 idle state", 32'(state2), 32'd0);
      check("dut2 idle ctl",   32'(ctl2),   32'(W_IDLE));
      for (int j = 0; j < 8; j++) begin
         // mem_ready2 is held low: FETCH must still complete in one cycle
         step2_check($sformatf("j%0d fetch", j),  4'd1,  W_FETCH_RDY, 3'(j));
         step2_check($sformatf("j%0d decode", j), 4'd2,  W_DECODE,    3'(j));
         step2_check($sformatf("j%0d jump", j),   4'd12, W_JUMP,      3'(j));
      end
      op2 = OP_SW;
      step2_check("wrap fetch",   4'd1, W_FETCH_RDY, 3'd0);
      step2_check("sw decode",    4'd2, W_DECODE,    3'd0);
      step2_check("sw memadr",    4'd3, W_MEMADR,    3'd0);
      step2_check("sw memwrite",  4'd6, W_MEMWR_RDY, 3'd0);
      step2_check("after sw",     4'd1, W_FETCH_RDY, 3'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mips_multiciclo_controle.md
Name: mips_multiciclo_controle

Overview:
- Multicycle control FSM for the team's MIPS core. It replaces the single-cycle decoder once the datapath shares one memory and one ALU across cycles.
- It sequences fetch, decode, execute, memory and writeback for add, sub, and, or, slt, lw, sw, beq, addi and j.
- It handshakes with the unified instruction/data memory, which may stall.
- It exposes a retired-instruction counter for the parallel I/O debug port.

Parameters:
- WAIT_MEM, 1: 1 = memory states hold until mem_ready; 0 = mem_ready treated as always 1.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- OP  input  6  opcode field from instruction register.
- Funct  input  6  funct field from instruction register.
- mem_ready  input  1  memory completed current access this cycle.
- mem_req  output  1  memory access request.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  PC load if ALU zero.
- PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- ULA_Control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- RegDst  output  1  1 = rd, 0 = rt.
- MemtoReg  output  1  1 = memory data, 0 = ALUOut.
- RegWrite  output  1  register file write.
- illegal_op  output  1  one-cycle pulse on unsupported OP/Funct.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- instr_count  output  CNT_W  retired-instruction count.
- state_o  output  4  current state encoding.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEXEC=10, ADDIWB=11, JUMP=12.
- Reset: when rst_n=0 at a clk edge, state<=IDLE and instr_count<=0.
  - All outputs are 0 in IDLE, including ULA_Control=000 and PCSrc=00.
  - Reset mid-instruction aborts it: no further writes, nothing retired.
- IDLE -> FETCH unconditionally.
- Outputs are decoded from the registered state. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ULA_Control=010, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ULA_Control=010. Next state by OP:
  - 100011 or 101011 -> MEMADR.
  - 000000 -> EXECUTE.
  - 000100 -> BRANCH.
  - 001000 -> ADDIEXEC.
  - 000010 -> JUMP.
  - Any other OP: illegal_op=1 and next state FETCH; PC has already advanced by 4.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ULA_Control=010. Goes to MEMREAD if OP=100011, else MEMWRITE.
- MEMREAD: mem_req=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; retires; goes to FETCH.
- MEMWRITE: mem_req=1, IorD=1, MemWrite=1. Holds until mem_ready, then retires and goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ULA_Control by Funct:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - Any other Funct: ULA_Control=000, illegal_op=1, next state FETCH with no write.
  - Valid Funct: next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; retires; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ULA_Control=110, Branch=1, PCSrc=01; retires; goes to FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ULA_Control=010; goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; retires; goes to FETCH.
- JUMP: PCWrite=1, PCSrc=10; retires; goes to FETCH.
- Retire: instr_done=1 in the retiring cycle, and instr_count increments at that clock edge.
  - instr_count wraps from 2^CNT_W-1 to 0.
  - Illegal instructions do not retire.
- Zero-wait cycle counts, including FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each memory wait cycle adds 1.
- mem_req is high only in FETCH, MEMREAD and MEMWRITE. MemWrite never asserts outside MEMWRITE.
- OP and Funct are stable from DECODE until the next FETCH; the block does not latch them.
- WAIT_MEM=0: every memory state lasts exactly 1 cycle regardless of mem_ready.

Test Plan:
- Release rst_n with mem_ready=1 and OP=000000, Funct=100000 -> state sequence 0,1,2,7,8,1. ULA_Control=010 in EXECUTE, RegWrite=RegDst=1 in ALUWB, instr_count=1.
- lw (OP=100011) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> FETCH lasts 3 cycles, MEMREAD lasts 4. IRWrite pulses once. MEMWB has RegWrite=1, MemtoReg=1, RegDst=0. Total 10 cycles.
- sw (101011) then beq (000100) then j (000010), zero-wait -> 4+3+3 cycles. MemWrite=1 only in MEMWRITE, Branch=1 with PCSrc=01 in BRANCH, PCWrite=1 with PCSrc=10 in JUMP. instr_count=3.
- OP=111111, then OP=000000 with Funct=000111 -> illegal_op pulses in DECODE and in EXECUTE. No RegWrite, instr_count unchanged, FSM returns to FETCH each time.
- Assert rst_n=0 in MEMWRITE while mem_ready=0 -> next cycle state=0 with all outputs 0 and instr_count=0. Then FETCH follows.
- Preload instr_count to 16'hFFFF via 65535 addi retirements (or force) -> next retire wraps it to 0 and instr_done=1.
